// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and one-hot state encodings for the RAM-backed FIFO controller
package fifo_pkg;
  localparam int WIDTH = 12;
  localparam int AW = 3;
  localparam int DEPTH = 2 ** AW;
  typedef enum logic [3:0] {
    S_RESET  = 4'b0001,
    S_INIT   = 4'b0010,
    S_IDLE   = 4'b0100,
    S_ACTIVE = 4'b1000,
    S_ERROR  = 4'b1111
  } state_t;
endpackage

// File: rtl/ram_fifo_fsm.sv
// ram_fifo_fsm: state register and next-state logic of the FIFO controller
//   clk, reset_L : clock, asynchronous active-low reset
//   init         : return to INIT from any operating or error state
//   illegal      : push while full or pop while empty this cycle
//   zero         : occupancy after this cycle's accesses is zero
//   state        : one-hot state (ERROR = 4'b1111)
module ram_fifo_fsm
  import fifo_pkg::*;
(
  input  logic   clk,
  input  logic   reset_L,
  input  logic   init,
  input  logic   illegal,
  input  logic   zero,
  output state_t state
);
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) state <= S_RESET;
    else
      case (state)
        S_RESET:          state <= S_INIT;
        S_INIT:           state <= init ? S_INIT : S_IDLE;
        S_IDLE, S_ACTIVE: state <= init ? S_INIT : illegal ? S_ERROR : zero ? S_IDLE : S_ACTIVE;
        default:          state <= init ? S_INIT : S_ERROR;
      endcase
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: sequences an external 8x12b dual-address RAM as a synchronous FIFO
//   clk, reset_L            : clock, asynchronous active-low reset
//   init                    : reload thresholds, clear pointers and count
//   umbral_af, umbral_ae    : almost-full / almost-empty thresholds, captured in INIT
//   push, data_in, pop      : producer / consumer requests
//   data_out, valid_out     : read data (q_a passthrough) and its strobe, 1 cycle after pop
//   full, empty, almost_full, almost_empty, error, state : status
//   data_a, addr_wa, addr_ra, we_a, re_a, q_a            : RAM side
//   fifo_count              : registered occupancy, present only with FIFO_COUNT_EN
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = fifo_pkg::WIDTH,
  parameter int AW = fifo_pkg::AW
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [AW:0]      umbral_af,
  input  logic [AW:0]      umbral_ae,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             error,
  output logic [3:0]       state,
  output logic [WIDTH-1:0] data_a,
  output logic [AW-1:0]    addr_wa,
  output logic [AW-1:0]    addr_ra,
  output logic             we_a,
  output logic             re_a,
  input  logic [WIDTH-1:0] q_a
`ifdef FIFO_COUNT_EN
  , output logic [AW:0]    fifo_count
`endif
);
  state_t          st;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, cnt_n, af_thr, ae_thr, af_n, ae_n;
  logic            op, ist, wr_ok, rd_ok, illegal;
  always_comb begin
    op      = st == S_IDLE || st == S_ACTIVE;
    ist     = st == S_INIT;
    wr_ok   = op && push && !full;
    rd_ok   = op && pop && !empty;
    illegal = op && ((push && full) || (pop && empty));
    cnt_n   = ist ? '0 : count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    af_n    = ist ? umbral_af : af_thr;
    ae_n    = ist ? umbral_ae : ae_thr;
  end
  assign we_a     = wr_ok;
  assign re_a     = rd_ok;
  assign addr_wa  = wr_ptr;
  assign addr_ra  = rd_ptr;
  assign data_a   = data_in;
  assign data_out = q_a;
  assign error    = st == S_ERROR;
  assign state    = st;
`ifdef FIFO_COUNT_EN
  assign fifo_count = count;
`endif
  ram_fifo_fsm u_fsm (
    .clk    (clk),
    .reset_L(reset_L),
    .init   (init),
    .illegal(illegal),
    .zero   (cnt_n == '0),
    .state  (st)
  );
  // Flags are registered from next-state values so they equal f(count, thresholds)
  // while still coming out of reset with the required 0/1 pattern.
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      af_thr       <= '0;
      ae_thr       <= '0;
      valid_out    <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= ist ? '0 : wr_ptr + AW'(wr_ok);
      rd_ptr       <= ist ? '0 : rd_ptr + AW'(rd_ok);
      count        <= cnt_n;
      af_thr       <= af_n;
      ae_thr       <= ae_n;
      valid_out    <= rd_ok;
      full         <= cnt_n[AW];
      empty        <= cnt_n == '0;
      almost_full  <= cnt_n >= af_n;
      almost_empty <= cnt_n <= ae_n;
    end
endmodule
